// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC sequencer with start/run/done control, branch via LUT target, stall/halt.
// Define PC_CALL_EN to enable the single-entry link register for call/return.
module pc_sequencer #(
  parameter int D = 12,
  parameter int L = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_stall,
  input  logic         i_halt_req,
  input  logic         i_branch_req,
  input  logic         i_branch_cond,
  input  logic         i_call_req,
  input  logic         i_ret_req,
  input  logic [L-1:0] i_lut_sel,
  input  logic [D-1:0] i_target,
  output logic [L-1:0] o_addr_lut,
  output logic [D-1:0] o_prog_ctr,
  output logic         o_running,
  output logic         o_done,
  output logic         o_branch_taken,
  output logic [D-1:0] o_link
);
`ifdef PC_CALL_EN
  localparam bit CALL_EN = 1'b1;
`else
  localparam bit CALL_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t       r_state, w_state_nxt;
  logic [D-1:0] r_prog_ctr, w_pc_nxt, r_link, w_link_nxt;
  logic         w_taken;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_prog_ctr <= '0;
      r_link     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_prog_ctr <= w_pc_nxt;
      r_link     <= w_link_nxt;
    end
  end
  // Without call support, ret falls through to increment and call behaves as a taken branch.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_prog_ctr;
    w_link_nxt  = r_link;
    w_taken     = 1'b0;
    if (r_state != RUN) begin
      if (i_start) begin
        w_state_nxt = RUN;
        w_pc_nxt    = '0;
      end
    end else if (!i_stall) begin
      if (i_halt_req) w_state_nxt = DONE;
      else if (CALL_EN && i_ret_req) w_pc_nxt = r_link;
      else if (i_call_req || (i_branch_req && i_branch_cond)) begin
        w_taken    = 1'b1;
        w_pc_nxt   = r_prog_ctr + i_target;
        w_link_nxt = (CALL_EN && i_call_req) ? r_prog_ctr + D'(1) : r_link;
      end else w_pc_nxt = r_prog_ctr + D'(1);
    end
  end
  assign o_addr_lut     = i_lut_sel;
  assign o_prog_ctr     = r_prog_ctr;
  assign o_link         = r_link;
  assign o_running      = r_state == RUN;
  assign o_done         = r_state == DONE;
  assign o_branch_taken = w_taken;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plan steps plus random cycles checked against a behavioural model.
module tb_pc_sequencer;
`ifdef PC_CALL_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic start = 0, stall = 0, halt_req = 0, branch_req = 0, branch_cond = 0, call_req = 0, ret_req = 0;
  logic [1:0] lut_sel = 0, addr_lut;
  logic [11:0] target, prog_ctr, link;
  logic running, done, branch_taken;
  logic [11:0] lut [4];
  int vectors = 0, miscompares = 0;
  int m_pc = 0, m_link = 0, m_st = 0;
  bit m_taken;

  pc_sequencer dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stall(stall), .i_halt_req(halt_req),
    .i_branch_req(branch_req), .i_branch_cond(branch_cond), .i_call_req(call_req),
    .i_ret_req(ret_req), .i_lut_sel(lut_sel), .i_target(target), .o_addr_lut(addr_lut),
    .o_prog_ctr(prog_ctr), .o_running(running), .o_done(done),
    .o_branch_taken(branch_taken), .o_link(link)
  );

  always #5 clk = ~clk;
  assign target = lut[addr_lut];

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".pc"}, int'(prog_ctr), m_pc);
    chk({tag, ".link"}, int'(link), m_link);
    chk({tag, ".running"}, int'(running), int'(m_st == 1));
    chk({tag, ".done"}, int'(done), int'(m_st == 2));
  endtask

  // Model: one clock of the sequencer computed from the priority rules, sums modulo 4096.
  task automatic apply(input string tag, input bit st, input bit sl, input bit h, input bit b,
                       input bit c, input bit ca, input bit r, input int sel);
    int t;
    start = st; stall = sl; halt_req = h; branch_req = b; branch_cond = c;
    call_req = ca; ret_req = r; lut_sel = 2'(sel);
    #1;
    t = int'(lut[sel]);
    m_taken = (m_st == 1) && !sl && !h && !(r && CE) && (ca || (b && c));
    chk({tag, ".addr_lut"}, int'(addr_lut), sel);
    chk({tag, ".taken"}, int'(branch_taken), int'(m_taken));
    @(posedge clk);
    if (m_st != 1) begin
      if (st) begin m_st = 1; m_pc = 0; end
    end else if (!sl) begin
      if (h) m_st = 2;
      else if (r && CE) m_pc = m_link;
      else if (ca || (b && c)) begin
        if (ca && CE) m_link = (m_pc + 1) % 4096;
        m_pc = (m_pc + t) % 4096;
      end else m_pc = (m_pc + 1) % 4096;
    end
    #1;
    chk_regs(tag);
  endtask

  initial begin
    lut[0] = 3; lut[1] = 4087; lut[2] = 4095; lut[3] = 8;
    #12;
    chk_regs("reset");
    chk("reset.taken", int'(branch_taken), 0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    apply("idle_hold", 0, 0, 0, 0, 0, 0, 0, 0);
    apply("start", 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) apply("inc", 0, 0, 0, 0, 0, 0, 0, 1);
    apply("br_taken", 0, 0, 0, 1, 1, 0, 0, 0);
    apply("br_not", 0, 0, 0, 1, 0, 0, 0, 0);
    apply("to_4095", 0, 0, 0, 1, 1, 0, 0, 1);
    apply("wrap", 0, 0, 0, 0, 0, 0, 0, 0);
    apply("inc", 0, 0, 0, 0, 0, 0, 0, 0);
    apply("inc", 0, 0, 0, 0, 0, 0, 0, 0);
    apply("neg_one", 0, 0, 0, 1, 1, 0, 0, 2);
    lut[2] = 0;
    apply("self_loop", 0, 0, 0, 1, 1, 0, 0, 2);
    apply("to_9", 0, 0, 0, 1, 1, 0, 0, 3);
    for (int i = 0; i < 3; i++) apply("stall", 0, 1, 0, 1, 1, 0, 0, 0);
    apply("unstall_br", 0, 0, 0, 1, 1, 0, 0, 0);
    apply("halt_br", 0, 0, 1, 1, 1, 0, 0, 0);
    apply("done_hold", 0, 0, 0, 1, 1, 0, 0, 0);
    apply("restart", 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) apply("inc", 0, 0, 0, 0, 0, 0, 0, 0);
    lut[1] = 20;
    apply("call", 0, 0, 0, 0, 0, 1, 0, 1);
    apply("after_call", 1, 0, 0, 0, 0, 0, 0, 1);
    apply("ret", 0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) lut[$urandom_range(0, 3)] = 12'($urandom);
      apply("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, int'($urandom_range(0, 3)));
    end
    apply("halt", 0, 0, 1, 0, 0, 0, 0, 0);
    apply("restart2", 1, 0, 0, 0, 0, 0, 0, 0);
    lut[3] = 17;
    apply("to_17", 0, 0, 0, 1, 1, 0, 0, 3);
    #2 rst = 1;
    #1;
    m_pc = 0; m_link = 0; m_st = 0;
    chk_regs("async_rst");
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) apply("post_rst_idle", 0, 0, 0, 1, 1, 0, 0, 3);
    apply("post_rst_start", 1, 0, 0, 0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
